// File: rtl/alu_pkg.sv
// Shared types for the chunk-serial ALU: opcode encoding, FSM states and
// a helper that marks the opcodes which produce arithmetic flags.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes 001 and 111 are not enumerated; they decode to a zero result.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bundle for serial_alu. A request transfers on a rising edge
// where in_valid_i=1 and in_ready_o=1; a response transfers on an edge where
// out_valid_o=1 and out_ready_i=1, and result_o/flags_o stay stable until then.
interface serial_alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [2:0]       op_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic [3:0]       flags_o;

    modport master (
        output in_valid_i, a_i, b_i, op_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, flags_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, flags_o
    );
endinterface

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit ALU slice. Subtraction inverts b here; the caller
// seeds cin=1 on the first slice so the chain computes a + ~b + 1.
module alu_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [CHUNK-1:0] out,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK:0]   sum;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
        cout  = sum[CHUNK];
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
        cmsb  = sum[CHUNK-1] ^ a[CHUNK-1] ^ b_eff[CHUNK-1];
        case (op)
            OP_PASSB:       out = b;
            OP_ADD, OP_SUB: out = sum[CHUNK-1:0];
            OP_AND:         out = a & b;
            OP_OR:          out = a | b;
            OP_XOR:         out = a ^ b;
            default:        out = '0;
        endcase
    end
endmodule

// File: rtl/serial_alu.sv
// Chunk-serial ALU: one CHUNK-bit slice per cycle, LSB chunk first, with the
// carry registered between slices. IDLE -> BUSY (N cycles) -> DONE.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    serial_alu_if.slave  bus,
    output state_e       state_dbg
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
            $error("serial_alu: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic [CHUNK-1:0] chunk_out;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic [WIDTH-1:0] a_next;
    logic [3:0]       flags_next;
    logic             last_chunk;

    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .op   (op_q),
        .out  (chunk_out),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    // a_q doubles as the result accumulator: consumed operand chunks shift
    // out at the bottom while result chunks enter at the top, so after N
    // shifts a_q holds the full result in place.
    always_comb begin
        a_next     = (a_q >> CHUNK) | (WIDTH'(chunk_out) << (WIDTH - CHUNK));
        last_chunk = (cnt_q == CW'(N - 1));
        flags_next = {a_next[WIDTH-1],
                      (a_next == '0),
                      is_arith(op_q) & (chunk_cmsb ^ chunk_cout),
                      is_arith(op_q) & chunk_cout};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (bus.flush_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid_i) begin
                        a_q        <= bus.a_i;
                        b_q        <= bus.b_i;
                        op_q       <= bus.op_i;
                        cnt_q      <= '0;
                        carry_q    <= (bus.op_i == OP_SUB);
                        in_ready_q <= 1'b0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    a_q     <= a_next;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= chunk_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        out_valid_q <= 1'b1;
                        result_q    <= a_next;
                        flags_q     <= flags_next;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Return to IDLE only; a new request is taken one cycle later.
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        result_q    <= '0;
                        flags_q     <= '0;
                        cnt_q       <= '0;
                        carry_q     <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.result_o    = result_q;
    assign bus.flags_o     = flags_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: stimulus pushes {flags, result} expectations
// into a queue; a negedge monitor pops and compares on every output handshake.
module tb_serial_alu;
    import alu_pkg::*;

    localparam int WIDTH = 64;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;
    localparam int W     = WIDTH + 4;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_e state_dbg;

    always #5 clk = ~clk;

    serial_alu_if #(.WIDTH(WIDTH)) bus ();

    serial_alu #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;
    logic mon_en     = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid_o && !prev_valid)
                check("latency", W'(cyc - accept_cyc), W'(N));
            if (!bus.out_valid_o) begin
                check("idle_outputs_zero", {bus.flags_o, bus.result_o}, '0);
            end else if (bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none",
                             {bus.flags_o, bus.result_o});
                end else begin
                    check("result_flags", {bus.flags_o, bus.result_o}, exp_q.pop_front());
                end
            end
            prev_valid = bus.out_valid_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input logic push,
                         input logic [3:0] fl, input logic [WIDTH-1:0] res);
        int n = 0;
        while (!bus.in_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        bus.in_valid_i = 1'b1;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.op_i       = op;
        if (push) exp_q.push_back({fl, res});
        @(posedge clk); #1;
        accept_cyc     = cyc;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid_o) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || state_dbg != ST_IDLE) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.op_i        = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", W'(bus.in_ready_o), W'(1'b1));
        check("reset_state", W'(state_dbg), W'(ST_IDLE));
        check("reset_outputs", {bus.flags_o, bus.result_o}, '0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: a, b, op, push, {N,Z,V,C}, result
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b010, 1'b1, 4'b1010, 64'h8000_0000_0000_0000);
        issue(64'h5, 64'h5, 3'b011, 1'b1, 4'b0101, 64'h0);
        issue(64'h0, 64'h1, 3'b011, 1'b1, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 1'b1, 4'b0000, 64'h0F0F_0F0F_0F0F_0F0F);
        issue(64'hDEAD_BEEF_1234_5678, 64'hCAFE_F00D_8765_4321, 3'b111, 1'b1, 4'b0100, 64'h0);
        issue(64'h1234_5678_9ABC_DEF0, 64'h5555_AAAA_5555_AAAA, 3'b001, 1'b1, 4'b0100, 64'h0);
        issue(64'h1111_2222_3333_4444, 64'h8000_0000_0000_0001, 3'b000, 1'b1, 4'b1000, 64'h8000_0000_0000_0001);
        issue(64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 3'b100, 1'b1, 4'b0000, 64'h0F00_0F00_0F00_0F00);
        issue(64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 3'b101, 1'b1, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b010, 1'b1, 4'b0101, 64'h0);
        issue(64'h8000_0000_0000_0000, 64'h1, 3'b011, 1'b1, 4'b0011, 64'h7FFF_FFFF_FFFF_FFFF);
        issue(64'h0000_0000_0000_00FF, 64'h1, 3'b010, 1'b1, 4'b0000, 64'h0000_0000_0000_0100);
        drain();

        // Back-pressure in DONE while new requests are offered
        bus.out_ready_i = 1'b0;
        issue(64'h1000, 64'h0234, 3'b010, 1'b1, 4'b0000, 64'h1234);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid_i = 1'b1;
            bus.a_i        = {$urandom, $urandom};
            bus.b_i        = {$urandom, $urandom};
            bus.op_i       = 3'($urandom_range(0, 7));
            @(negedge clk);
            check("hold_result", {bus.flags_o, bus.result_o}, {4'b0000, 64'h1234});
            check("hold_in_ready", W'(bus.in_ready_o), W'(1'b0));
            @(posedge clk); #1;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", W'(bus.in_ready_o), W'(1'b1));
        check("release_state", W'(state_dbg), W'(ST_IDLE));
        @(posedge clk); #1;

        // Flush during chunk 3, then a clean add
        issue(64'h5, 64'h6, 3'b010, 1'b0, 4'b0000, 64'h0);
        repeat (3) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_state", W'(state_dbg), W'(ST_IDLE));
        check("flush_in_ready", W'(bus.in_ready_o), W'(1'b1));
        repeat (12) @(posedge clk);
        #1;
        issue(64'h1, 64'h2, 3'b010, 1'b1, 4'b0000, 64'h3);
        drain();

        // Flush beats a simultaneous request in IDLE
        bus.in_valid_i = 1'b1;
        bus.flush_i    = 1'b1;
        bus.a_i        = 64'h9;
        bus.op_i       = 3'b010;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        @(negedge clk);
        check("flush_idle_state", W'(state_dbg), W'(ST_IDLE));
        check("flush_idle_ready", W'(bus.in_ready_o), W'(1'b1));
        @(posedge clk); #1;

        // Reset while a result is pending in DONE
        bus.out_ready_i = 1'b0;
        issue(64'h7, 64'h8, 3'b010, 1'b0, 4'b0000, 64'h0);
        wait_valid();
        @(negedge clk);
        check("pre_reset_valid", W'(bus.out_valid_o), W'(1'b1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_done_valid", W'(bus.out_valid_o), W'(1'b0));
        check("rst_done_outputs", {bus.flags_o, bus.result_o}, '0);
        check("rst_done_in_ready", W'(bus.in_ready_o), W'(1'b1));
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;

        issue(64'h10, 64'h20, 3'b101, 1'b1, 4'b0000, 64'h30);
        drain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", W'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  synchronous, active-low reset.
REQ-005 in_valid_i  input  1  operand request valid.
REQ-006 in_ready_o  output  1  block can accept a request.
REQ-007 a_i  input  WIDTH  operand A.
REQ-008 b_i  input  WIDTH  operand B.
REQ-009 op_i  input  3  opcode: 000 B, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 A^B, 001/111 zero.
REQ-010 flush_i  input  1  synchronous abort of any operation in progress.
REQ-011 out_valid_o  output  1  result and flags valid.
REQ-012 out_ready_i  input  1  consumer takes result.
REQ-013 result_o  output  WIDTH  operation result.
REQ-014 flags_o  output  4  {negative, zero, overflow, carry}.

Function
REQ-015 FSM states IDLE, BUSY, DONE; in_ready_o SHALL be 1 only in IDLE.
REQ-016 IDLE: on in_valid_i=1, latch a_i, b_i, op_i; clear chunk counter; seed carry = 1 for 011, else 0; go BUSY.
REQ-017 BUSY: each cycle process chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK), k = 0 .. N-1, N = WIDTH/CHUNK, LSB chunk first; carry register propagates chunk to chunk.
REQ-018 Sub SHALL compute A + ~B + 1; carry = carry out of bit WIDTH-1 (1 = no borrow).
REQ-019 After chunk N-1 go DONE; out_valid_o SHALL rise exactly N edges after the accepting edge.
REQ-020 DONE: result_o and flags_o held stable while out_valid_o=1 and out_ready_i=0; on out_ready_i=1 go IDLE (one-cycle bubble: no accept in the same cycle as DONE->IDLE).
REQ-021 negative = result bit WIDTH-1; zero = (result == 0), all ops.
REQ-022 overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, for 010/011 only; overflow and carry SHALL be 0 for all other opcodes.
REQ-023 Inputs a_i, b_i, op_i, in_valid_i SHALL be ignored outside IDLE.
REQ-024 flush_i=1 in any state: next state IDLE, out_valid_o=0, result_o/flags_o cleared; in IDLE flush_i wins over in_valid_i (no accept).
REQ-025 result_o and flags_o SHALL read 0 whenever out_valid_o=0.

Reset
REQ-026 rst_ni=0 at an edge: state IDLE, in_ready_o=1 next cycle, out_valid_o=0, result_o=0, flags_o=0, counter and carry 0; reset overrides flush_i and aborts BUSY/DONE without producing output.

Structure
REQ-027 Package alu_pkg SHALL hold the opcode enum (OP_PASSB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR) and the FSM state enum.
REQ-028 One sub-module alu_chunk (parameter CHUNK): combinational CHUNK-bit slice taking a, b, cin, op; producing out, cout, and carry into its MSB.
REQ-029 Chunk counter width SHALL be clog2(N), minimum 1.

Verification (WIDTH=64, CHUNK=8, N=8)
REQ-030 ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, flags {1,0,1,0}, out_valid_o 8 edges after accept.
REQ-031 SUB 5 - 5 -> result 0, flags {0,1,0,1}; SUB 0 - 1 -> result 0xFFFF_FFFF_FFFF_FFFF, flags {1,0,0,0}.
REQ-032 XOR 0xF0F0..F0 ^ 0xFFFF..FF -> 0x0F0F..0F, flags {0,0,0,0}; op 111 any operands -> result 0, flags {0,1,0,0}.
REQ-033 Hold out_ready_i=0 five cycles in DONE while driving in_valid_i=1 and new operands -> result/flags unchanged, in_ready_o=0; release -> IDLE, in_ready_o=1 next cycle.
REQ-034 flush_i=1 at BUSY chunk 3 -> IDLE next edge, no out_valid_o; following ADD 1+2 -> 3 correctly.
REQ-035 rst_ni=0 during DONE with out_valid_o=1 -> next edge out_valid_o=0, result_o=0, flags_o=0, in_ready_o=1.
